// File: rtl/uart_rx.sv
// UART receiver, 8N1 framing (1 start, 8 data LSB first, 1 stop, no parity).
// The serial line is double-flopped and each bit is sampled at its midpoint.
// Good bytes are presented with a one-cycle valid strobe. A low stop bit gives
// a one-cycle framing-error strobe instead.
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_RX_Serial    asynchronous serial input, idles high
//   o_RX_DV        one-cycle strobe: o_RX_Byte holds a new good byte
//   o_RX_Byte      last correctly received byte, held until the next good one
//   o_RX_Frame_Err one-cycle strobe: stop bit sampled low
//   o_RX_Active    high while a frame is being received (start..stop)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Active
);

    localparam logic [15:0] BitMax  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfMax = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        ferr_q, ferr_d;
    logic        active_q, active_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_q      <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        case (state_q)
            StIdle: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                if (!rx_q) begin
                    state_d  = StStart;
                    active_d = 1'b1;
                end
            end

            StStart: begin
                if (cnt_q == HalfMax) begin
                    cnt_d = '0;
                    if (!rx_q) begin
                        state_d = StData;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d  = StIdle;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StData: begin
                if (cnt_q == BitMax) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StStop: begin
                if (cnt_q == BitMax) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = StCleanup;
                    if (rx_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StCleanup: begin
                cnt_d = '0;
                // A held-low (break) line parks here so it is not taken as a start.
                if (rx_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d  = StIdle;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Frame_Err = ferr_q;
    assign o_RX_Active    = active_q;

endmodule
